pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Sequencing controller for the five-stage MIPS32 pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage enable and flush controls for the PC and the four pipeline buffers.
- Handles load-use stalls, branch-taken flushes (branch resolves in MEM) and wait states from a multi-cycle data memory.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt
WAIT_MAX, 15, consecutive memory-wait cycles before err_timeout sets (1..255)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
id_rs  input  5  rs field of IF/ID instruction [25:21]
id_rt  input  5  rt field of IF/ID instruction [20:16]
id_uses_rt  input  1  IF/ID instruction reads rt (R-type, beq, sw)
ex_mem_read  input  1  MemToRead from ID/EX
ex_rt  input  5  load destination rt from ID/EX
mem_branch  input  1  Branch from EX/MEM
mem_zero  input  1  Zero_Flag from EX/MEM
mem_access  input  1  MemToRead or MemToWrite from EX/MEM
mem_ready  input  1  data memory completes access this cycle
pc_en  output  1  PC load enable
ifid_en  output  1  IF/ID load enable
ifid_flush  output  1  IF/ID loads bubble (all zero)
idex_en  output  1  ID/EX load enable
idex_flush  output  1  ID/EX loads bubble (control bits zero)
exmem_en  output  1  EX/MEM load enable
exmem_flush  output  1  EX/MEM loads bubble
memwb_flush  output  1  MEM/WB loads bubble (RegWrite=0)
state  output  2  current FSM state, for debug
stall_cnt  output  CNT_W  load-use stall cycles, saturating
flush_cnt  output  CNT_W  branch flush events, saturating
err_timeout  output  1  sticky: memory wait reached WAIT_MAX

Behaviour:
- FSM states:
  - RUN=0
  - LU_STALL=1
  - BR_FLUSH=2
  - MEM_WAIT=3
- Reset asserted (reset=0), async:
  - state=RUN, counters=0, err_timeout=0, wait counter=0.
  - Outputs forced to: all *_en=0, all *_flush=1.
- Control outputs are combinational from state and inputs; they act on the same edge. Default is all enables 1, all flushes 0.
- Event decode, evaluated in priority order each cycle:
  1. wait = mem_access & !mem_ready.
  2. taken = mem_branch & mem_zero & !wait.
  3. lu = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)) & !wait & !taken & (state!=BR_FLUSH).
- wait:
  - Outputs: pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1.
  - Next state MEM_WAIT; wait counter increments.
  - When the wait counter reaches WAIT_MAX, err_timeout sets; stalling continues.
  - In MEM_WAIT with mem_ready=1: outputs are normal, the wait counter clears and the FSM returns to RUN.
- taken:
  - Outputs: ifid_flush=idex_flush=exmem_flush=1, all enables 1. The PC takes the branch target via the datapath mux.
  - Next state BR_FLUSH; flush_cnt+1.
- BR_FLUSH lasts exactly one cycle and suppresses lu; then RUN unless another event fires.
- lu:
  - Outputs: pc_en=0, ifid_en=0, idex_flush=1.
  - Next state LU_STALL; stall_cnt+1.
- LU_STALL lasts one cycle. ID/EX then holds a bubble, so lu deasserts naturally. Next state RUN or any newly decoded event.
- Load-use latency: exactly one bubble cycle per dependent load.
- Branch penalty: exactly three squashed instructions.
- Simultaneous events:
  - taken + lu: flush only; stall_cnt is unchanged.
  - wait + taken/lu: wait only; the others are re-evaluated once mem_ready=1.
- ex_rt==0 ($zero) never causes a stall.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset mid-stall or mid-wait returns immediately to the reset values above.

Decomposition:
- Shared package `mips_pipe_pkg` holds:
  - state encodings RUN/LU_STALL/BR_FLUSH/MEM_WAIT;
  - REG_ZERO=5'd0;
  - opcode constants used to derive id_uses_rt in the top level.
- One natural sub-module, `sat_counter` (parameter W, inputs inc/clr, async active-low reset), instantiated for stall_cnt and flush_cnt.
- The wait counter stays inline.

Test Plan:
- Load-use: lw $2,0($1) then add $3,$2,$4 (ex_mem_read=1, ex_rt=2, id_rs=2) -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; state=1; stall_cnt=1; next cycle all enables 1.
- $zero: ex_rt=0, id_rs=0, ex_mem_read=1 -> no stall; stall_cnt stays 0.
- Branch taken: mem_branch=1, mem_zero=1 -> ifid/idex/exmem_flush=1 for one cycle; flush_cnt=1; state=2, then 0. Repeat with mem_zero=0 -> no flush.
- Taken + load-use same cycle -> flushes only; pc_en=1; stall_cnt unchanged; flush_cnt increments.
- Memory wait: mem_access=1, mem_ready=0 for 3 cycles, then 1 -> pc/ifid/idex/exmem_en=0 and memwb_flush=1 for 3 cycles; state=3; resume in RUN; err_timeout=0. Hold for 15 cycles -> err_timeout=1, sticky until reset.
- Reset mid-MEM_WAIT (reset=0 asynchronously) -> state=0, counters=0, err_timeout=0 immediately; enables=0 and flushes=1 while low.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS32 five-stage pipeline control logic.
//   state_e        : hazard controller FSM encoding (also exported on the debug port)
//   REG_ZERO       : architectural $zero register index
//   OP_*           : primary opcodes relevant to operand usage
//   op_reads_rt()  : decoder helper that yields the id_uses_rt qualifier
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2,
        MEM_WAIT = 2'd3
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // True when the instruction reads rt as a source operand. A load writes
    // rt and does not read it, so it is deliberately excluded.
    function automatic logic op_reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear (wins over inc)
//   cnt        : current count, holds at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing controller for the five-stage MIPS32 pipeline.
// Produces PC / pipeline-buffer enables and flushes for load-use stalls,
// branch-taken squashes (branch resolved in MEM) and data-memory wait states.
//   clk, reset                 : clock, asynchronous active-low reset
//   id_rs, id_rt, id_uses_rt   : source operands of the instruction in IF/ID
//   ex_mem_read, ex_rt         : load in ID/EX and its destination
//   mem_branch, mem_zero       : branch resolution in EX/MEM
//   mem_access, mem_ready      : data-memory handshake for the EX/MEM access
//   pc_en .. memwb_flush       : same-edge pipeline controls
//   state                      : FSM state (debug)
//   stall_cnt, flush_cnt       : saturating performance counters
//   err_timeout                : sticky memory-wait timeout
module pipeline_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             err_timeout
);

    localparam logic [7:0] WAIT_LIMIT = 8'(WAIT_MAX);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       err_q, err_d;

    logic wait_ev;
    logic taken;
    logic lu;

    // Priority decode: a memory wait freezes everything, and a taken branch
    // squashes the very instruction a load-use stall would have held.
    assign wait_ev = mem_access && !mem_ready;
    assign taken   = mem_branch && mem_zero && !wait_ev;
    assign lu      = ex_mem_read && (ex_rt != REG_ZERO)
                     && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)))
                     && !wait_ev && !taken && (state_q != BR_FLUSH);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = RUN;
        wait_cnt_d = '0;
        err_d      = err_q;
        if (wait_ev) begin
            state_d = MEM_WAIT;
            // Hold at the limit so a very long wait cannot wrap the counter.
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 8'd1;
            if (wait_cnt_d == WAIT_LIMIT) begin
                err_d = 1'b1;
            end
        end else if (taken) begin
            state_d = BR_FLUSH;
        end else if (lu) begin
            state_d = LU_STALL;
        end
    end

    // Output logic; reset overrides to a fully frozen, bubble-filled pipe.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!reset) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_en     = 1'b0;
            idex_flush  = 1'b1;
            exmem_en    = 1'b0;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (wait_ev) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (lu) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (lu),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (taken),
        .clr   (1'b0),
        .cnt   (flush_cnt)
    );

    assign state       = state_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Control outputs are packed as {pc_en, ifid_en, ifid_flush, idex_en,
// idex_flush, exmem_en, exmem_flush, memwb_flush}.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W    = 3;
    localparam int WAIT_MAX = 15;

    localparam logic [7:0] C_NORM  = 8'hD4;
    localparam logic [7:0] C_RST   = 8'h2B;
    localparam logic [7:0] C_WAIT  = 8'h01;
    localparam logic [7:0] C_TAKEN = 8'hFE;
    localparam logic [7:0] C_LU    = 8'h1C;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_mem_read, mem_branch, mem_zero;
    logic             mem_access, mem_ready;
    logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic             exmem_en, exmem_flush, memwb_flush;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             err_timeout;
    logic [7:0]       ctl;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, exmem_flush, memwb_flush};

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .mem_branch  (mem_branch),
        .mem_zero    (mem_zero),
        .mem_access  (mem_access),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
        .state       (state),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .err_timeout (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; ex_rt = 5'd0;
        mem_branch = 1'b0; mem_zero = 1'b0;
        mem_access = 1'b0; mem_ready = 1'b1;
    endtask

    // Inputs are already applied; check combinational controls mid-cycle,
    // then the registered state just after the next rising edge.
    task automatic cycle(input string tag, input logic [7:0] exp_ctl, input logic [1:0] exp_state);
        @(negedge clk);
        chk({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
        @(posedge clk); #1;
        chk({tag, "_state"}, 32'(state), 32'(exp_state));
        $display("step %-12s ctl=%02h state=%0d stall=%0d flush=%0d err=%0b",
                 tag, ctl, state, stall_cnt, flush_cnt, err_timeout);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        #3;
        chk("rst_ctl", 32'(ctl), 32'(C_RST));
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush_cnt), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        #9 reset = 1'b1;
        @(posedge clk); #1;

        cycle("idle", C_NORM, 2'd0);

        // lw $2 then add $3,$2,$4
        ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
        cycle("lu_rs", C_LU, 2'd1);
        chk("lu_rs_stall", 32'(stall_cnt), 32'd1);
        ex_mem_read = 1'b0;
        cycle("lu_release", C_NORM, 2'd0);

        // $zero destination never stalls
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        cycle("lu_zero", C_NORM, 2'd0);
        chk("lu_zero_stall", 32'(stall_cnt), 32'd1);

        // rt dependency only counts when the consumer reads rt
        ex_rt = 5'd5; id_rt = 5'd5; id_rs = 5'd3; id_uses_rt = 1'b0;
        cycle("lu_rt_unused", C_NORM, 2'd0);
        id_uses_rt = 1'b1;
        cycle("lu_rt", C_LU, 2'd1);
        chk("lu_rt_stall", 32'(stall_cnt), 32'd2);
        clear_inputs();
        cycle("idle2", C_NORM, 2'd0);

        // Taken branch, then a hazard during BR_FLUSH is suppressed
        mem_branch = 1'b1; mem_zero = 1'b1;
        cycle("br_taken", C_TAKEN, 2'd2);
        chk("br_taken_flush", 32'(flush_cnt), 32'd1);
        clear_inputs();
        ex_mem_read = 1'b1; ex_rt = 5'd2; id_rs = 5'd2;
        cycle("br_supp_lu", C_NORM, 2'd0);
        chk("br_supp_stall", 32'(stall_cnt), 32'd2);
        clear_inputs();
        mem_branch = 1'b1; mem_zero = 1'b0;
        cycle("br_not_taken", C_NORM, 2'd0);
        chk("br_nt_flush", 32'(flush_cnt), 32'd1);

        // Taken + load-use together: flush only
        mem_zero = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd7; id_rs = 5'd7;
        cycle("br_and_lu", C_TAKEN, 2'd2);
        chk("br_and_lu_stall", 32'(stall_cnt), 32'd2);
        chk("br_and_lu_flush", 32'(flush_cnt), 32'd2);
        clear_inputs();
        cycle("idle3", C_NORM, 2'd0);

        // Three wait cycles with a taken branch pending behind them
        mem_access = 1'b1; mem_ready = 1'b0; mem_branch = 1'b1; mem_zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle("mem_wait", C_WAIT, 2'd3);
        end
        chk("wait_flush_held", 32'(flush_cnt), 32'd2);
        chk("wait_err", 32'(err_timeout), 32'd0);
        mem_ready = 1'b1;
        cycle("wait_done_br", C_TAKEN, 2'd2);
        chk("wait_done_flush", 32'(flush_cnt), 32'd3);
        clear_inputs();
        cycle("idle4", C_NORM, 2'd0);
        chk("idle4_err", 32'(err_timeout), 32'd0);

        // Timeout: flag appears after exactly WAIT_MAX wait cycles
        mem_access = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < WAIT_MAX - 1; i++) begin
            cycle("long_wait", C_WAIT, 2'd3);
        end
        chk("tmo_before", 32'(err_timeout), 32'd0);
        cycle("long_wait_last", C_WAIT, 2'd3);
        chk("tmo_set", 32'(err_timeout), 32'd1);
        mem_ready = 1'b1;
        cycle("tmo_resume", C_NORM, 2'd0);
        clear_inputs();
        cycle("idle5", C_NORM, 2'd0);
        chk("tmo_sticky", 32'(err_timeout), 32'd1);

        // flush_cnt saturates at 7 with CNT_W=3
        for (int i = 0; i < 5; i++) begin
            mem_branch = 1'b1; mem_zero = 1'b1;
            cycle("sat_br", C_TAKEN, 2'd2);
            chk("sat_flush", 32'(flush_cnt), (4 + i > 7) ? 32'd7 : 32'(4 + i));
            clear_inputs();
            cycle("sat_gap", C_NORM, 2'd0);
        end

        // Asynchronous reset in the middle of a memory wait
        mem_access = 1'b1; mem_ready = 1'b0;
        cycle("pre_rst_wait", C_WAIT, 2'd3);
        #2 reset = 1'b0;
        #1;
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_stall", 32'(stall_cnt), 32'd0);
        chk("arst_flush", 32'(flush_cnt), 32'd0);
        chk("arst_err", 32'(err_timeout), 32'd0);
        chk("arst_ctl", 32'(ctl), 32'(C_RST));
        @(negedge clk);
        chk("arst_ctl_hold", 32'(ctl), 32'(C_RST));
        clear_inputs();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        cycle("post_rst", C_NORM, 2'd0);
        chk("post_rst_err", 32'(err_timeout), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute bound so the run always ends on its own.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
